// File: rtl/btb_upd_queue_if.sv
// btb_upd_queue_if: execute-side update channel plus BTB write port of the update queue
interface btb_upd_queue_if #(parameter int DEPTH = 4);
  logic upd_valid;
  logic upd_ready;
  logic upd_invalid;
  logic [31:1] upd_pc;
  logic [31:0] upd_target;
  logic fetch_rd;
  logic btb_wr;
  logic btb_invalid;
  logic [31:1] pc_w;
  logic [31:0] target_pc_w;
  logic rd_stolen;
  logic [$clog2(DEPTH):0] cnt;
  modport master (
    output upd_valid, upd_invalid, upd_pc, upd_target, fetch_rd,
    input upd_ready, btb_wr, btb_invalid, pc_w, target_pc_w, rd_stolen, cnt
  );
  modport slave (
    input upd_valid, upd_invalid, upd_pc, upd_target, fetch_rd,
    output upd_ready, btb_wr, btb_invalid, pc_w, target_pc_w, rd_stolen, cnt
  );
endinterface

// File: rtl/btb_upd_queue.sv
// btb_upd_queue: FIFO of resolved-branch updates drained into the BTB write port with a starvation guard.
// Define BTB_UPDQ_MERGE_EN to merge an update into a queued entry with the same pc.
module btb_upd_queue #(
  parameter int DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input logic clk,
  input logic reset,
  btb_upd_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [AW:0] wp, rp, cnt_v;
  logic [SW-1:0] starve;
  logic inv_m [DEPTH];
  logic [31:1] pc_m [DEPTH];
  logic [31:0] tgt_m [DEPTH];
  logic empty, full, frc, pop, push, merge;
  logic [DEPTH-1:0] hit;
  assign cnt_v = wp - rp;
  assign empty = wp == rp;
  assign full = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign frc = starve == SW'(STARVE_MAX);
  assign pop = !empty && (!q.fetch_rd || frc);
  assign push = q.upd_valid && !full;
  assign q.upd_ready = !full;
  assign q.cnt = cnt_v;
  assign q.btb_wr = pop;
  assign q.rd_stolen = pop && q.fetch_rd;
  assign q.btb_invalid = inv_m[rp[AW-1:0]];
  assign q.pc_w = pc_m[rp[AW-1:0]];
  assign q.target_pc_w = tgt_m[rp[AW-1:0]];
`ifdef BTB_UPDQ_MERGE_EN
  // A live entry matches unless it is the head leaving this cycle.
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++)
      hit[i] = ({1'b0, AW'(AW'(i) - rp[AW-1:0])} < cnt_v) && (pc_m[i] == q.upd_pc)
               && !(pop && AW'(i) == rp[AW-1:0]);
  end
`else
  assign hit = '0;
`endif
  assign merge = |hit;
  always_ff @(posedge clk)
    for (int i = 0; i < DEPTH; i++)
      if (push && (merge ? hit[i] : AW'(i) == wp[AW-1:0])) begin
        inv_m[i] <= q.upd_invalid;
        pc_m[i] <= q.upd_pc;
        tgt_m[i] <= q.upd_target;
      end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      starve <= '0;
    end else begin
      if (push && !merge) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      starve <= (empty || pop) ? '0 : starve + SW'(1);
    end
  end
endmodule

// File: tb/tb_btb_upd_queue.sv
// tb_btb_upd_queue: vector table plus scoreboarded corner sequences for btb_upd_queue
module tb_btb_upd_queue;
  localparam int DEPTH = 4;
  localparam int SMAX = 8;
`ifdef BTB_UPDQ_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  btb_upd_queue_if #(.DEPTH(DEPTH)) bus();
  btb_upd_queue #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (.clk(clk), .reset(reset), .q(bus.slave));
  typedef struct {logic inv; logic [31:1] pc; logic [31:0] tgt;} ent_t;
  typedef struct {
    logic v; logic inv; logic [31:1] pc; logic [31:0] tgt; logic fr;
    int ecnt; logic ewr; logic erdy;
  } vec_t;
  ent_t sb[$];
  logic [31:0] got[$];
  vec_t vt[9];
  int ms = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic s_wr, s_st, s_rdy;
  int s_cnt;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic inv, input logic [31:1] pc, input logic [31:0] tgt, input logic fr);
    int sz, hi;
    logic ew, er;
    bus.upd_valid = v;
    bus.upd_invalid = inv;
    bus.upd_pc = pc;
    bus.upd_target = tgt;
    bus.fetch_rd = fr;
    #1;
    sz = sb.size();
    ew = sz != 0 && (!fr || ms == SMAX);
    er = sz != DEPTH;
    s_wr = bus.btb_wr;
    s_st = bus.rd_stolen;
    s_rdy = bus.upd_ready;
    s_cnt = int'(bus.cnt);
    chk("cnt", bus.cnt, sz);
    chk("upd_ready", bus.upd_ready, er);
    chk("btb_wr", bus.btb_wr, ew);
    chk("rd_stolen", bus.rd_stolen, ew && fr);
    if (ew) begin
      chk("pc_w", bus.pc_w, sb[0].pc);
      chk("target_pc_w", bus.target_pc_w, sb[0].tgt);
      chk("btb_invalid", bus.btb_invalid, sb[0].inv);
      got.push_back(bus.target_pc_w);
    end
    ms = (sz == 0 || ew) ? 0 : ms + 1;
    hi = -1;
    if (v && er && MERGE)
      for (int i = ew ? 1 : 0; i < sz; i++) if (sb[i].pc == pc) hi = i;
    if (ew) begin
      void'(sb.pop_front());
      if (hi >= 0) hi--;
    end
    if (v && er) begin
      if (hi >= 0) begin
        sb[hi].inv = inv;
        sb[hi].tgt = tgt;
      end else sb.push_back('{inv, pc, tgt});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic drain();
    for (int t = 0; t < 20 && sb.size() != 0; t++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    chk("drained_cnt", bus.cnt, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int blocked;
    logic fired;
    logic [31:0] exp_t[$];
    vt[0] = '{1'b0, 1'b0, 31'h0,   32'h0,    1'b0, 0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 31'h800, 32'h2000, 1'b0, 0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b0, 31'h0,   32'h0,    1'b0, 1, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b0, 31'h0,   32'h0,    1'b0, 0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 31'h900, 32'h3001, 1'b1, 0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 31'hA00, 32'h4000, 1'b1, 1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 31'h0,   32'h0,    1'b0, 2, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b0, 31'h0,   32'h0,    1'b0, 1, 1'b1, 1'b1};
    vt[8] = '{1'b0, 1'b0, 31'h0,   32'h0,    1'b0, 0, 1'b0, 1'b1};
    bus.upd_valid = 1'b0;
    bus.upd_invalid = 1'b0;
    bus.upd_pc = '0;
    bus.upd_target = '0;
    bus.fetch_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cyc(vt[i].v, vt[i].inv, vt[i].pc, vt[i].tgt, vt[i].fr);
      chk("vec_cnt", s_cnt, vt[i].ecnt);
      chk("vec_btb_wr", s_wr, vt[i].ewr);
      chk("vec_upd_ready", s_rdy, vt[i].erdy);
    end
    blocked = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 31'h1100 + 31'(k), 32'h100 + 32'(k), 1'b1);
      if (s_cnt != 0 && !s_wr) blocked++;
    end
    fired = 1'b0;
    for (int t = 0; t < 30 && !fired; t++) begin
      cyc(1'b1, 1'b0, 31'h15F0, 32'h5F0, 1'b1);
      if (t == 0) begin
        chk("full_cnt", s_cnt, DEPTH);
        chk("full_ready", s_rdy, 1'b0);
      end
      if (s_wr) fired = 1'b1;
      else blocked++;
    end
    chk("force_fired", fired, 1'b1);
    chk("starve_wait", blocked, SMAX);
    chk("force_stolen", s_st, 1'b1);
    chk("force_ready_still_low", s_rdy, 1'b0);
    cyc(1'b1, 1'b0, 31'h15F0, 32'h5F0, 1'b1);
    chk("ready_after_force", s_rdy, 1'b1);
    chk("no_wr_after_force", s_wr, 1'b0);
    drain();
    cyc(1'b1, 1'b0, 31'h2000, 32'h7000, 1'b1);
    cyc(1'b1, 1'b0, 31'h2001, 32'h7001, 1'b1);
    for (int k = 2; k < 12; k++) begin
      cyc(1'b1, k[0], 31'h2000 + 31'(k), 32'h7000 + 32'(k), 1'b0);
      chk("pushpop_cnt", s_cnt, 2);
      chk("pushpop_wr", s_wr, 1'b1);
    end
    drain();
    got.delete();
    cyc(1'b1, 1'b0, 31'h0A0A, 32'h100, 1'b1);
    cyc(1'b1, 1'b0, 31'h0B0B, 32'h0B0, 1'b1);
    cyc(1'b1, 1'b0, 31'h0A0A, 32'h200, 1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b1);
    chk("merge_cnt", s_cnt, MERGE ? 2 : 3);
    drain();
    if (MERGE) exp_t = '{32'h200, 32'h0B0};
    else exp_t = '{32'h100, 32'h0B0, 32'h200};
    chk("merge_drain_len", got.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < got.size(); i++) chk("merge_drain_tgt", got[i], exp_t[i]);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 31'h3000 + 31'(k), 32'h9000 + 32'(k), 1'b1);
    chk("pre_reset_cnt", s_cnt, 2);
    chk("pre_reset_live_cnt", bus.cnt, 3);
    bus.upd_valid = 1'b0;
    bus.fetch_rd = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    ms = 0;
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_btb_wr", bus.btb_wr, 1'b0);
    chk("rst_upd_ready", bus.upd_ready, 1'b1);
    chk("rst_rd_stolen", bus.rd_stolen, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, '0, '0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
